// File: rtl/vector_op_sequencer.sv
// Vector operation sequencer: issues a decoded vector op one element per ack.
// Optional per-element masking is compiled in with `define VSEQ_MASK_EN.
module vector_op_sequencer #(
  parameter int LANES = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Opcode,
  input  logic [1:0]       S,
  input  logic [IDX_W:0]   Len,
`ifdef VSEQ_MASK_EN
  input  logic [LANES-1:0] Mask,
`endif
  input  logic             Flush,
  input  logic             ElemAck,
  output logic             Busy,
  output logic             Stall,
  output logic             ElemValid,
  output logic [IDX_W-1:0] ElemIdx,
  output logic             ElemRegW,
  output logic             ElemMemW,
  output logic             ElemMemtoReg,
  output logic             Done,
  output logic             Error
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [2:0]       op_reg, op_next;
  logic [1:0]       s_reg, s_next;
  logic [IDX_W:0]   len_reg, len_next;
  logic [LANES-1:0] mask_reg, start_mask;
  logic [LANES-1:0] start_bits, above_bits;
  logic [IDX_W:0]   len_eff;
  logic             legal, accept, start_any, more_above, cur_en;

  assign legal   = (Opcode == 3'b001) ||
                   ((Opcode == 3'b101) && ((S == 2'b00) || (S == 2'b01)));
  assign len_eff = (Len > (IDX_W+1)'(LANES)) ? (IDX_W+1)'(LANES) : Len;
  assign accept  = Start && legal && !Flush;

`ifdef VSEQ_MASK_EN
  logic [LANES-1:0] mask_next;
  assign start_mask = Mask;
  assign mask_next  = ((state_reg == IDLE) && accept) ? Mask : mask_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_reg <= '0;
    else        mask_reg <= mask_next;
  end
`else
  assign start_mask = '1;
  assign mask_reg   = '1;
`endif

  // Lanes still to be issued: at Start (from index 0) and above the current index.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign start_bits[gi] = start_mask[gi] && ((IDX_W+1)'(gi) < len_eff);
      assign above_bits[gi] = mask_reg[gi] && ((IDX_W+1)'(gi) < len_reg) &&
                              ((IDX_W+1)'(gi) > {1'b0, idx_reg});
    end
  endgenerate

  assign start_any  = |start_bits;
  assign more_above = |above_bits;
  assign cur_en     = mask_reg[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      op_reg    <= '0;
      s_reg     <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      op_reg    <= op_next;
      s_reg     <= s_next;
      len_reg   <= len_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    op_next    = op_reg;
    s_next     = s_reg;
    len_next   = len_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next    = Opcode;
          s_next     = S;
          len_next   = len_eff;
          idx_next   = '0;
          state_next = start_any ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (Flush) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (!cur_en || ElemAck) begin
          // Masked-off lanes advance without waiting for an ack.
          if (more_above) idx_next = idx_reg + IDX_W'(1);
          else            state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_comb begin
    Busy         = (state_reg != IDLE);
    Stall        = 1'b0;
    ElemValid    = 1'b0;
    ElemRegW     = 1'b0;
    ElemMemW     = 1'b0;
    ElemMemtoReg = 1'b0;
    Done         = 1'b0;
    Error        = 1'b0;
    case (state_reg)
      IDLE: begin
        Stall = rst_n && accept && (len_eff != '0);
        Error = rst_n && Start && !legal && !Flush;
      end
      ISSUE: begin
        Stall     = 1'b1;
        ElemValid = cur_en;
        if (cur_en) begin
          ElemRegW     = (op_reg == 3'b001) || (s_reg == 2'b01);
          ElemMemW     = (op_reg == 3'b101) && (s_reg == 2'b00);
          ElemMemtoReg = (op_reg == 3'b101) && (s_reg == 2'b01);
        end
      end
      DONE: Done = !Flush;
      default: ;
    endcase
  end

  assign ElemIdx = idx_reg;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Self-checking bench for vector_op_sequencer: directed scenarios plus random ops
// checked cycle by cycle against an element-schedule model.
module tb_vector_op_sequencer;
  localparam int LANES = 4;
  localparam int IDX_W = 2;
  localparam int VW    = 8 + IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             Start = 1'b0;
  logic [2:0]       Opcode = '0;
  logic [1:0]       S = '0;
  logic [IDX_W:0]   Len = '0;
  logic             Flush = 1'b0;
  logic             ElemAck = 1'b0;
`ifdef VSEQ_MASK_EN
  logic [LANES-1:0] Mask = '0;
`endif
  logic             Busy, Stall, ElemValid, ElemRegW, ElemMemW, ElemMemtoReg, Done, Error;
  logic [IDX_W-1:0] ElemIdx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vector_op_sequencer #(.LANES(LANES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Opcode(Opcode), .S(S), .Len(Len),
`ifdef VSEQ_MASK_EN
    .Mask(Mask),
`endif
    .Flush(Flush), .ElemAck(ElemAck), .Busy(Busy), .Stall(Stall),
    .ElemValid(ElemValid), .ElemIdx(ElemIdx), .ElemRegW(ElemRegW),
    .ElemMemW(ElemMemW), .ElemMemtoReg(ElemMemtoReg), .Done(Done), .Error(Error)
  );

  function automatic logic [VW-1:0] pack(input bit busy, input bit stall, input bit valid,
                                         input int idx, input bit rw, input bit mw,
                                         input bit m2r, input bit done, input bit err);
    logic [IDX_W-1:0] ix;
    ix = idx[IDX_W-1:0];
    return {busy, stall, valid, ix, rw, mw, m2r, done, err};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] exp, input bit idx_care);
    logic [VW-1:0] care, obs;
    care = '1;
    if (!idx_care) care[IDX_W+4:5] = '0;
    obs = {Busy, Stall, ElemValid, ElemIdx, ElemRegW, ElemMemW, ElemMemtoReg, Done, Error};
    tests++;
    assert ((obs & care) === (exp & care)) else begin
      fails++;
      $error("FAIL %s: observed %b required %b (busy,stall,valid,idx,regw,memw,m2r,done,err)",
             tag, obs & care, exp & care);
    end
  endtask

  task automatic drive(input bit st, input logic [2:0] op, input logic [1:0] s, input int len,
                       input bit ack, input bit fl);
    @(negedge clk);
    Start = st; Opcode = op; S = s; Len = len[IDX_W:0]; ElemAck = ack; Flush = fl;
    #1;
  endtask

  // Random Start/Opcode/Len while busy: these must be ignored.
  task automatic drive_busy(input bit noise, input bit ack, input bit fl);
    if (noise)
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 7), ack, fl);
    else
      drive(1'b0, 3'b000, 2'b00, 0, ack, fl);
  endtask

  task automatic idle_check(input string tag, input bit idx_care);
    drive(1'b0, 3'b000, 2'b00, 0, 1'b0, 1'b0);
    check({tag, "/idle"}, pack(0, 0, 0, 0, 0, 0, 0, 0, 0), idx_care);
  endtask

  // Model: elements below min(Len,LANES) with a set mask bit are issued in order,
  // each held until its ack; clear bits cost one idle cycle unless none remain.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] s, input int len,
                        input logic [LANES-1:0] msk, input int mind, input int maxd,
                        input int flush_beat, input bit flush_done, input bit noise);
    int  leff, last, beats, d;
    bit  legal, rw, mw, m2r, fl;
    leff  = (len > LANES) ? LANES : len;
    legal = (op == 3'b001) || ((op == 3'b101) && (s inside {2'b00, 2'b01}));
    rw    = (op == 3'b001) || (s == 2'b01);
    mw    = (op == 3'b101) && (s == 2'b00);
    m2r   = (op == 3'b101) && (s == 2'b01);
    last  = -1;
    for (int i = 0; i < leff; i++) if (msk[i]) last = i;
`ifdef VSEQ_MASK_EN
    Mask = msk;
`endif
    drive(1'b1, op, s, len, 1'($urandom_range(0, 1)), 1'b0);
    check({tag, "/start"}, pack(0, legal && (leff > 0), 0, 0, 0, 0, 0, 0, !legal), 0);
    if (!legal) begin
      idle_check(tag, 0);
      return;
    end
    beats = 0;
    for (int idx = 0; idx <= last; idx++) begin
      if (msk[idx]) begin
        d = $urandom_range(mind, maxd);
        for (int c = 0; c <= d; c++) begin
          fl = (beats == flush_beat) && (c == d);
          drive_busy(noise, c == d, fl);
          check($sformatf("%s/elem%0d", tag, idx), pack(1, 1, 1, idx, rw, mw, m2r, 0, 0), 1);
          if (fl) begin
            idle_check({tag, "/flushed"}, 1);
            return;
          end
        end
        beats++;
      end else begin
        drive_busy(noise, 1'($urandom_range(0, 1)), 1'b0);
        check($sformatf("%s/skip%0d", tag, idx), pack(1, 1, 0, idx, 0, 0, 0, 0, 0), 1);
      end
    end
    drive_busy(noise, 1'($urandom_range(0, 1)), flush_done);
    check({tag, "/done"}, pack(1, 0, 0, 0, 0, 0, 0, !flush_done, 0), 0);
    idle_check(tag, flush_done);
  endtask

  function automatic logic [LANES-1:0] rand_mask();
`ifdef VSEQ_MASK_EN
    return LANES'($urandom);
`else
    return '1;
`endif
  endfunction

  initial begin
    logic [2:0] op;
    logic [1:0] s;
    int         sel, fb;

    // Reset with a legal Start pending: every output must stay low.
    Start = 1'b1; Opcode = 3'b001; Len = 3'd4; ElemAck = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_hold", pack(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    @(negedge clk);
    #1 check("reset_hold2", pack(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    Start = 1'b0; ElemAck = 1'b0;
    rst_n = 1'b1;
    idle_check("reset", 1);

    run_op("arith_len4", 3'b001, 2'b00, 4, '1, 0, 0, -1, 0, 0);
    run_op("store_len2_d3", 3'b101, 2'b00, 2, '1, 3, 3, -1, 0, 0);
    run_op("load_len3", 3'b101, 2'b01, 3, '1, 0, 2, -1, 0, 1);
    run_op("illegal_s10", 3'b101, 2'b10, 4, '1, 0, 0, -1, 0, 0);
    run_op("illegal_op", 3'b011, 2'b00, 4, '1, 0, 0, -1, 0, 0);
    run_op("len0", 3'b001, 2'b00, 0, '1, 0, 0, -1, 0, 0);
    run_op("len7", 3'b101, 2'b01, 7, '1, 0, 1, -1, 0, 0);
    run_op("flush_idx2", 3'b001, 2'b00, 4, '1, 0, 0, 2, 0, 0);
    run_op("flush_done", 3'b101, 2'b00, 1, '1, 0, 0, -1, 1, 0);

    // Flush in IDLE beats Start: no Stall, no Error, operation dropped.
    drive(1'b1, 3'b001, 2'b00, 4, 1'b0, 1'b1);
    check("idle_flush_legal", pack(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    drive(1'b1, 3'b111, 2'b00, 4, 1'b0, 1'b1);
    check("idle_flush_illegal", pack(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    idle_check("idle_flush", 1);

    // Reset in the middle of ISSUE abandons the op with every output low at once.
    drive(1'b1, 3'b001, 2'b00, 4, 1'b0, 1'b0);
    check("rst_mid/start", pack(0, 1, 0, 0, 0, 0, 0, 0, 0), 1);
    drive(1'b0, 3'b000, 2'b00, 0, 1'b1, 1'b0);
    check("rst_mid/elem0", pack(1, 1, 1, 0, 1, 0, 0, 0, 0), 1);
    drive(1'b1, 3'b001, 2'b00, 4, 1'b0, 1'b0);
    check("rst_mid/elem1", pack(1, 1, 1, 1, 1, 0, 0, 0, 0), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid/in_reset", pack(0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    @(negedge clk);
    Start = 1'b0;
    rst_n = 1'b1;
    idle_check("rst_mid", 1);
    idle_check("rst_mid_nodone", 1);

`ifdef VSEQ_MASK_EN
    run_op("mask1010", 3'b001, 2'b00, 4, 4'b1010, 0, 0, -1, 0, 0);
    run_op("mask0000", 3'b001, 2'b00, 4, 4'b0000, 0, 0, -1, 0, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      op  = (sel < 2) ? 3'b001 : (sel == 2) ? 3'b101 : 3'($urandom_range(0, 7));
      s   = 2'($urandom_range(0, 3));
      fb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LANES - 1) : -1;
      run_op($sformatf("rnd%0d", n), op, s, $urandom_range(0, 7), rand_mask(), 0,
             $urandom_range(0, 3), fb, ($urandom_range(0, 5) == 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within the time budget");
    $fatal(1, "timeout");
  end

endmodule
